// File: rtl/ledr_rx_if.sv
// ledr_rx_if: LEDR rails, two-phase ack and the valid/ready output stream of the receiver
interface ledr_rx_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] ledr_v;
    logic [WIDTH-1:0] ledr_t;
    logic             ack_o;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             ready_i;
    logic [1:0]       level_o;
    modport master (output ledr_v, ledr_t, ready_i, input ack_o, data_o, valid_o, level_o);
    modport slave  (input ledr_v, ledr_t, ready_i, output ack_o, data_o, valid_o, level_o);
endinterface

// File: rtl/ledr_rx.sv
// ledr_rx: synchronises an LEDR word, detects completion, buffers it in a 2-entry FIFO, returns a two-phase ack
module ledr_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic     clk,
    input logic     rst,
    ledr_rx_if.slave bus
);
    typedef enum logic [1:0] {WAIT, CHECK, STALL} state_t;
    state_t                            state_q, state_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] v_sync_q, v_sync_d, t_sync_q, t_sync_d;
    logic [WIDTH-1:0]                  vs, ts, head_q, head_d, tail_q, tail_d;
    logic [1:0]                        level_q, level_d;
    logic                              exp_q, exp_d, ack_q, ack_d, valid_q, valid_d;
    logic                              complete, pop, space, push;
    always_comb begin
        v_sync_d = {v_sync_q[SYNC_STAGES-2:0], bus.ledr_v};
        t_sync_d = {t_sync_q[SYNC_STAGES-2:0], bus.ledr_t};
        vs       = v_sync_q[SYNC_STAGES-1];
        ts       = t_sync_q[SYNC_STAGES-1];
        complete = ((vs ^ ts) == {WIDTH{exp_q}});
        pop      = valid_q & bus.ready_i;
        space    = (level_q != 2'd2) | pop;
        // STALL trusts the held word; CHECK needs a second complete sample to ride out skew
        push     = space & ((state_q == STALL) | ((state_q == CHECK) & complete));
        state_d  = push ? WAIT :
                   (state_q == WAIT)  ? (complete ? CHECK : WAIT) :
                   (state_q == CHECK) ? (complete ? STALL : WAIT) : STALL;
        ack_d    = push ? exp_q : ack_q;
        exp_d    = exp_q ^ push;
        level_d  = level_q + {1'b0, push} - {1'b0, pop};
        valid_d  = (level_d != 2'd0);
        head_d   = (pop & (level_q == 2'd2)) ? tail_q :
                   (push & ((level_q == 2'd0) | (pop & (level_q == 2'd1)))) ? vs : head_q;
        tail_d   = (push & ((level_q == 2'd2) ? pop : ((level_q == 2'd1) & ~pop))) ? vs : tail_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT;
            v_sync_q <= '0;
            t_sync_q <= '0;
            exp_q    <= 1'b1;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            level_q  <= 2'd0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            state_q  <= state_d;
            v_sync_q <= v_sync_d;
            t_sync_q <= t_sync_d;
            exp_q    <= exp_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
            level_q  <= level_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
        end
    end
    assign bus.ack_o   = ack_q;
    assign bus.data_o  = head_q;
    assign bus.valid_o = valid_q;
    assign bus.level_o = level_q;
endmodule

// File: tb/tb_ledr_rx.sv
// tb_ledr_rx: LEDR sender model plus in-order scoreboard around ledr_rx
module tb_ledr_rx;
    localparam int W = 8;
    localparam int S = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   done = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pops_n = 0;
    logic sent_ph = 1'b0;
    logic [W-1:0] exp_q[$];
    always #5 clk = ~clk;
    ledr_rx_if #(.WIDTH(W)) bus();
    ledr_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask
    // Each bit toggles exactly one rail towards phase ~sent_ph, bits landing at random steps
    task automatic present(input logic [W-1:0] word, input int spread);
        int d[W];
        logic ph;
        logic [W-1:0] t;
        @(posedge clk);
        #1;
        ph = ~sent_ph;
        t  = word ^ {W{ph}};
        foreach (d[i]) d[i] = int'($urandom_range(spread, 0));
        if (spread > 0) d[$urandom_range(W-1, 0)] = spread;
        for (int s = 0; s <= spread; s++) begin
            if (s > 0) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < W; i++)
                if (d[i] == s) begin
                    bus.ledr_v[i] = word[i];
                    bus.ledr_t[i] = t[i];
                end
        end
        sent_ph = ph;
        exp_q.push_back(word);
    endtask
    task automatic wait_ack(input logic ph);
        for (int i = 0; i < 300 && bus.ack_o !== ph; i++) cyc(1);
        check("ack", {31'd0, bus.ack_o}, {31'd0, ph});
    endtask
    task automatic drive_ready(input logic r);
        @(posedge clk);
        #1 bus.ready_i = r;
    endtask
    always @(negedge clk)
        if (!rst && bus.valid_o && bus.ready_i) begin
            check("pop_avail", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) check("pop_data", {24'd0, bus.data_o}, {24'd0, exp_q.pop_front()});
            pops_n++;
        end
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.ledr_v  = '0;
        bus.ledr_t  = '0;
        bus.ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ack", {31'd0, bus.ack_o}, 32'd0);
        check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        check("rst_level", {30'd0, bus.level_o}, 32'd0);
        check("rst_data", {24'd0, bus.data_o}, 32'd0);
        present(8'hA5, 0);
        for (int k = 1; k <= S + 2; k++) begin
            cyc(1);
            check("lat_valid", {31'd0, bus.valid_o}, {31'd0, k == S + 2});
            check("lat_ack", {31'd0, bus.ack_o}, {31'd0, k == S + 2});
        end
        check("w1_data", {24'd0, bus.data_o}, 32'hA5);
        drive_ready(1'b1);
        present(8'h3C, 0);
        wait_ack(1'b0);
        check("w2_data", {24'd0, bus.data_o}, 32'h3C);
        cyc(10);
        check("repeat_valid", {31'd0, bus.valid_o}, 32'd0);
        check("repeat_level", {30'd0, bus.level_o}, 32'd0);
        check("repeat_ack", {31'd0, bus.ack_o}, 32'd0);
        drive_ready(1'b0);
        present(8'h96, 4);
        for (int k = 1; k <= S + 2; k++) begin
            cyc(1);
            check("skew_valid", {31'd0, bus.valid_o}, {31'd0, k == S + 2});
        end
        check("skew_data", {24'd0, bus.data_o}, 32'h96);
        cyc(10);
        check("skew_level", {30'd0, bus.level_o}, 32'd1);
        drive_ready(1'b1);
        cyc(3);
        drive_ready(1'b0);
        present(8'h11, 1);
        wait_ack(1'b0);
        present(8'h22, 2);
        wait_ack(1'b1);
        check("full_level", {30'd0, bus.level_o}, 32'd2);
        present(8'h33, 0);
        cyc(20);
        check("stall_level", {30'd0, bus.level_o}, 32'd2);
        check("stall_ack", {31'd0, bus.ack_o}, 32'd1);
        check("stall_data", {24'd0, bus.data_o}, 32'h11);
        drive_ready(1'b1);
        drive_ready(1'b0);
        @(negedge clk);
        check("swap_level", {30'd0, bus.level_o}, 32'd2);
        check("swap_ack", {31'd0, bus.ack_o}, 32'd0);
        check("swap_data", {24'd0, bus.data_o}, 32'h22);
        present(8'h44, 0);
        cyc(S + 4);
        check("pre_rst_level", {30'd0, bus.level_o}, 32'd2);
        check("pre_rst_ack", {31'd0, bus.ack_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc(1);
        check("midrst_valid", {31'd0, bus.valid_o}, 32'd0);
        check("midrst_level", {30'd0, bus.level_o}, 32'd0);
        check("midrst_ack", {31'd0, bus.ack_o}, 32'd0);
        exp_q.delete();
        exp_q.push_back(8'h44);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_ack(1'b1);
        check("recap_data", {24'd0, bus.data_o}, 32'h44);
        check("recap_level", {30'd0, bus.level_o}, 32'd1);
        pops_n = 0;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    present(W'($urandom), int'($urandom_range(3, 0)));
                    wait_ack(sent_ph);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.ready_i = 1'($urandom_range(1, 0));
                end
            end
        join
        drive_ready(1'b1);
        cyc(10);
        check("drain_queue", exp_q.size(), 32'd0);
        check("drain_valid", {31'd0, bus.valid_o}, 32'd0);
        check("drain_pops", pops_n, 32'd1001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
